// File: rtl/axi_aw_ar_b_frontend.sv
// AXI4 AW/AR command front-end: holds one address per channel, arbitrates,
// splits bursts into native beats and returns B responses in AW order.
// Ports: clk/rst, AXI AW/AR slave channels, AXI B master channel,
// native command master channel, wburst_done completion pulse.
// Optional: define AXI_QOS_ARB_EN for qos-priority arbitration.
module axi_aw_ar_b_frontend #(
  parameter int DATA_BYTES = 32,
  parameter int BID_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_aw_valid,
  output logic        axi_aw_ready,
  input  logic        axi_aw_first,
  input  logic        axi_aw_last,
  input  logic [31:0] axi_aw_payload_addr,
  input  logic [1:0]  axi_aw_payload_burst,
  input  logic [7:0]  axi_aw_payload_len,
  input  logic [3:0]  axi_aw_payload_size,
  input  logic [1:0]  axi_aw_payload_lock,
  input  logic [2:0]  axi_aw_payload_prot,
  input  logic [3:0]  axi_aw_payload_cache,
  input  logic [3:0]  axi_aw_payload_qos,
  input  logic        axi_aw_payload_id,
  input  logic        axi_ar_valid,
  output logic        axi_ar_ready,
  input  logic        axi_ar_first,
  input  logic        axi_ar_last,
  input  logic [31:0] axi_ar_payload_addr,
  input  logic [1:0]  axi_ar_payload_burst,
  input  logic [7:0]  axi_ar_payload_len,
  input  logic [3:0]  axi_ar_payload_size,
  input  logic [1:0]  axi_ar_payload_lock,
  input  logic [2:0]  axi_ar_payload_prot,
  input  logic [3:0]  axi_ar_payload_cache,
  input  logic [3:0]  axi_ar_payload_qos,
  input  logic        axi_ar_payload_id,
  output logic        axi_b_valid,
  input  logic        axi_b_ready,
  output logic        axi_b_first,
  output logic        axi_b_last,
  output logic [1:0]  axi_b_payload_resp,
  output logic        axi_b_payload_id,
  output logic        native_cmd_valid,
  input  logic        native_cmd_ready,
  output logic        native_cmd_first,
  output logic        native_cmd_last,
  output logic        native_cmd_payload_we,
  output logic        native_cmd_payload_mw,
  output logic [31:0] native_cmd_payload_addr,
  output logic        native_cmd_id,
  input  logic        wburst_done
);

  localparam int WS = $clog2(DATA_BYTES);
  localparam int PW = $clog2(BID_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [3:0]  size;
    logic [3:0]  qos;
    logic        id;
  } cmd_t;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic [1:0] {
    M_FIXED, M_INCR, M_WRAP
  } mode_t;

  function automatic logic wrap_ok(input logic [7:0] l);
    return (l == 8'd1) || (l == 8'd3) ||
           (l == 8'd7) || (l == 8'd15);
  endfunction

  cmd_t   aw_q, ar_q, sel;
  logic   aw_full, ar_full;
  logic   aw_hs, ar_hs, cmd_hs, b_hs;
  logic   aw_err;
  logic   load, pick_aw, last_aw;
  state_t state, state_n;

  logic [31:0] e_addr, e_next, step, mask, inc;
  logic [7:0]  e_len, beat;
  logic [3:0]  e_size, sel_size;
  mode_t       e_mode, sel_mode;
  logic        e_id, e_we, is_last;

  logic [1:0]  mem [BID_DEPTH];
  logic [PW:0] wp, rp, count, cnt;
  logic        f_full, f_empty, cnt_inc;
  logic [1:0]  head;

  // ---------------- acceptance ----------------
  assign f_full  = (count == (PW+1)'(BID_DEPTH));
  assign f_empty = (count == '0);

  assign axi_aw_ready = !rst && !aw_full && !f_full;
  assign axi_ar_ready = !rst && !ar_full;
  assign aw_hs = axi_aw_valid && axi_aw_ready;
  assign ar_hs = axi_ar_valid && axi_ar_ready;

  assign aw_err =
    (axi_aw_payload_burst == 2'd3) ||
    (axi_aw_payload_size > 4'(WS)) ||
    ((axi_aw_payload_burst == 2'd2) &&
     !wrap_ok(axi_aw_payload_len));

  // ---------------- arbitration ----------------
  assign load = (state == IDLE) && (aw_full || ar_full);

  always_comb begin
    pick_aw = 1'b0;
    if (aw_full && !ar_full)
      pick_aw = 1'b1;
    else if (aw_full && ar_full) begin
`ifdef AXI_QOS_ARB_EN
      if (aw_q.qos > ar_q.qos)
        pick_aw = 1'b1;
      else if (ar_q.qos > aw_q.qos)
        pick_aw = 1'b0;
      else
        pick_aw = !last_aw;
`else
      pick_aw = !last_aw;
`endif
    end
  end

  assign sel = pick_aw ? aw_q : ar_q;

  // Reserved bursts and illegal WRAP lengths run as INCR.
  always_comb begin
    sel_mode = M_INCR;
    unique case (1'b1)
      (sel.burst == 2'd0):
        sel_mode = M_FIXED;
      (sel.burst == 2'd2) && wrap_ok(sel.len):
        sel_mode = M_WRAP;
      default:
        sel_mode = M_INCR;
    endcase
  end

  assign sel_size = (sel.size > 4'(WS)) ?
                    4'(WS) : sel.size;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full <= 1'b0;
      ar_full <= 1'b0;
      aw_q    <= '0;
      ar_q    <= '0;
      last_aw <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_q <= '{addr:  axi_aw_payload_addr,
                  burst: axi_aw_payload_burst,
                  len:   axi_aw_payload_len,
                  size:  axi_aw_payload_size,
                  qos:   axi_aw_payload_qos,
                  id:    axi_aw_payload_id};
      end else if (load && pick_aw)
        aw_full <= 1'b0;
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_q <= '{addr:  axi_ar_payload_addr,
                  burst: axi_ar_payload_burst,
                  len:   axi_ar_payload_len,
                  size:  axi_ar_payload_size,
                  qos:   axi_ar_payload_qos,
                  id:    axi_ar_payload_id};
      end else if (load && !pick_aw)
        ar_full <= 1'b0;
      if (load)
        last_aw <= pick_aw;
    end
  end

  // ---------------- burst engine ----------------
  assign cmd_hs  = native_cmd_valid && native_cmd_ready;
  assign is_last = (beat == e_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (load) state_n = ISSUE;
      ISSUE: if (cmd_hs && is_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // WRAP keeps the bits above the (len+1)<<size window.
  assign step = 32'd1 << e_size;
  assign mask = (({24'd0, e_len} + 32'd1) << e_size)
                - 32'd1;
  assign inc  = e_addr + step;

  always_comb begin
    e_next = inc;
    unique case (e_mode)
      M_FIXED: e_next = e_addr;
      M_WRAP:  e_next = (e_addr & ~mask) | (inc & mask);
      default: e_next = inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_addr <= '0;
      e_len  <= '0;
      e_size <= '0;
      e_mode <= M_INCR;
      e_id   <= 1'b0;
      e_we   <= 1'b0;
      beat   <= '0;
    end else if (load) begin
      e_addr <= sel.addr;
      e_len  <= sel.len;
      e_size <= sel_size;
      e_mode <= sel_mode;
      e_id   <= sel.id;
      e_we   <= pick_aw;
      beat   <= '0;
    end else if (cmd_hs) begin
      e_addr <= e_next;
      beat   <= beat + 8'd1;
    end
  end

  assign native_cmd_valid = (state == ISSUE);
  assign native_cmd_first = native_cmd_valid &&
                            (beat == 8'd0);
  assign native_cmd_last  = native_cmd_valid && is_last;
  assign native_cmd_payload_we   = e_we;
  assign native_cmd_payload_mw   = 1'b0;
  assign native_cmd_payload_addr = e_addr >> WS;
  assign native_cmd_id           = e_id;

  // ---------------- B path ----------------
  assign count = wp - rp;
  assign head  = mem[rp[PW-1:0]];
  assign b_hs  = axi_b_valid && axi_b_ready;
  // Completions beyond the outstanding writes are dropped.
  assign cnt_inc = wburst_done && (cnt < count);

  always_ff @(posedge clk) begin
    if (aw_hs)
      mem[wp[PW-1:0]] <= {axi_aw_payload_id, aw_err};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (aw_hs) wp <= wp + 1'b1;
      if (b_hs)  rp <= rp + 1'b1;
      if (cnt_inc && !b_hs)
        cnt <= cnt + 1'b1;
      else if (b_hs && !cnt_inc)
        cnt <= cnt - 1'b1;
    end
  end

  assign axi_b_valid = !f_empty && (cnt != '0);
  assign axi_b_first = axi_b_valid;
  assign axi_b_last  = axi_b_valid;
  assign axi_b_payload_id   = axi_b_valid && head[1];
  assign axi_b_payload_resp = (axi_b_valid && head[0]) ?
                              2'b10 : 2'b00;

  logic unused_ok;
`ifdef AXI_QOS_ARB_EN
  assign unused_ok = ^{axi_aw_first, axi_aw_last,
    axi_aw_payload_lock, axi_aw_payload_prot,
    axi_aw_payload_cache, axi_ar_first, axi_ar_last,
    axi_ar_payload_lock, axi_ar_payload_prot,
    axi_ar_payload_cache};
`else
  assign unused_ok = ^{axi_aw_first, axi_aw_last,
    axi_aw_payload_lock, axi_aw_payload_prot,
    axi_aw_payload_cache, axi_ar_first, axi_ar_last,
    axi_ar_payload_lock, axi_ar_payload_prot,
    axi_ar_payload_cache, aw_q.qos, ar_q.qos};
`endif

endmodule

// File: tb/tb_axi_aw_ar_b_frontend.sv
// Directed self-checking bench for axi_aw_ar_b_frontend.
module tb_axi_aw_ar_b_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axi_aw_valid = 0, axi_aw_ready;
  logic        axi_aw_first = 0, axi_aw_last = 0;
  logic [31:0] axi_aw_payload_addr = 0;
  logic [1:0]  axi_aw_payload_burst = 0;
  logic [7:0]  axi_aw_payload_len = 0;
  logic [3:0]  axi_aw_payload_size = 0;
  logic [1:0]  axi_aw_payload_lock = 0;
  logic [2:0]  axi_aw_payload_prot = 0;
  logic [3:0]  axi_aw_payload_cache = 0;
  logic [3:0]  axi_aw_payload_qos = 0;
  logic        axi_aw_payload_id = 0;
  logic        axi_ar_valid = 0, axi_ar_ready;
  logic        axi_ar_first = 0, axi_ar_last = 0;
  logic [31:0] axi_ar_payload_addr = 0;
  logic [1:0]  axi_ar_payload_burst = 0;
  logic [7:0]  axi_ar_payload_len = 0;
  logic [3:0]  axi_ar_payload_size = 0;
  logic [1:0]  axi_ar_payload_lock = 0;
  logic [2:0]  axi_ar_payload_prot = 0;
  logic [3:0]  axi_ar_payload_cache = 0;
  logic [3:0]  axi_ar_payload_qos = 0;
  logic        axi_ar_payload_id = 0;
  logic        axi_b_valid, axi_b_ready = 0;
  logic        axi_b_first, axi_b_last;
  logic [1:0]  axi_b_payload_resp;
  logic        axi_b_payload_id;
  logic        native_cmd_valid, native_cmd_ready = 0;
  logic        native_cmd_first, native_cmd_last;
  logic        native_cmd_payload_we, native_cmd_payload_mw;
  logic [31:0] native_cmd_payload_addr;
  logic        native_cmd_id;
  logic        wburst_done = 0;

  int passed = 0;
  int total  = 0;

  logic [31:0] ca  [16];
  logic        cw  [16];
  logic        cf  [16];
  logic        cl  [16];
  logic        cid [16];
  int          cn;
  logic        exp_we;

  always #5 clk = ~clk;

  axi_aw_ar_b_frontend dut (
    .clk(clk), .rst(rst),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_first(axi_aw_first), .axi_aw_last(axi_aw_last),
    .axi_aw_payload_addr(axi_aw_payload_addr),
    .axi_aw_payload_burst(axi_aw_payload_burst),
    .axi_aw_payload_len(axi_aw_payload_len),
    .axi_aw_payload_size(axi_aw_payload_size),
    .axi_aw_payload_lock(axi_aw_payload_lock),
    .axi_aw_payload_prot(axi_aw_payload_prot),
    .axi_aw_payload_cache(axi_aw_payload_cache),
    .axi_aw_payload_qos(axi_aw_payload_qos),
    .axi_aw_payload_id(axi_aw_payload_id),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_first(axi_ar_first), .axi_ar_last(axi_ar_last),
    .axi_ar_payload_addr(axi_ar_payload_addr),
    .axi_ar_payload_burst(axi_ar_payload_burst),
    .axi_ar_payload_len(axi_ar_payload_len),
    .axi_ar_payload_size(axi_ar_payload_size),
    .axi_ar_payload_lock(axi_ar_payload_lock),
    .axi_ar_payload_prot(axi_ar_payload_prot),
    .axi_ar_payload_cache(axi_ar_payload_cache),
    .axi_ar_payload_qos(axi_ar_payload_qos),
    .axi_ar_payload_id(axi_ar_payload_id),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
    .axi_b_first(axi_b_first), .axi_b_last(axi_b_last),
    .axi_b_payload_resp(axi_b_payload_resp),
    .axi_b_payload_id(axi_b_payload_id),
    .native_cmd_valid(native_cmd_valid),
    .native_cmd_ready(native_cmd_ready),
    .native_cmd_first(native_cmd_first),
    .native_cmd_last(native_cmd_last),
    .native_cmd_payload_we(native_cmd_payload_we),
    .native_cmd_payload_mw(native_cmd_payload_mw),
    .native_cmd_payload_addr(native_cmd_payload_addr),
    .native_cmd_id(native_cmd_id),
    .wburst_done(wburst_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a,
                         input logic [1:0] b,
                         input logic [7:0] l,
                         input logic [3:0] s,
                         input logic id);
    logic ok;
    axi_aw_payload_addr  = a;
    axi_aw_payload_burst = b;
    axi_aw_payload_len   = l;
    axi_aw_payload_size  = s;
    axi_aw_payload_id    = id;
    axi_aw_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (axi_aw_ready) ok = 1'b1;
      tick();
    end
    axi_aw_valid = 1'b0;
    chk("aw_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_ar(input logic [31:0] a,
                         input logic [1:0] b,
                         input logic [7:0] l,
                         input logic [3:0] s,
                         input logic id);
    logic ok;
    axi_ar_payload_addr  = a;
    axi_ar_payload_burst = b;
    axi_ar_payload_len   = l;
    axi_ar_payload_size  = s;
    axi_ar_payload_id    = id;
    axi_ar_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (axi_ar_ready) ok = 1'b1;
      tick();
    end
    axi_ar_valid = 1'b0;
    chk("ar_accept", 32'(ok), 32'd1);
  endtask

  task automatic collect(input int n);
    cn = 0;
    for (int i = 0; i < 40 && cn < n; i++) begin
      if (native_cmd_valid && native_cmd_ready) begin
        ca[cn]  = native_cmd_payload_addr;
        cw[cn]  = native_cmd_payload_we;
        cf[cn]  = native_cmd_first;
        cl[cn]  = native_cmd_last;
        cid[cn] = native_cmd_id;
        cn++;
      end
      tick();
    end
    chk("ncmds", 32'(cn), 32'(n));
  endtask

  task automatic done_pulse();
    wburst_done = 1'b1;
    tick();
    wburst_done = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_aw_ready", 32'(axi_aw_ready), 0);
    chk("rst_ar_ready", 32'(axi_ar_ready), 0);
    chk("rst_cmd_valid", 32'(native_cmd_valid), 0);
    chk("rst_b_valid", 32'(axi_b_valid), 0);
    chk("rst_cmd_addr", native_cmd_payload_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_aw_ready", 32'(axi_aw_ready), 1);

    // AR INCR burst
    native_cmd_ready = 1'b1;
    send_ar(32'h100, 2'd1, 8'd3, 4'd5, 1'b1);
    collect(4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_addr%0d", i), ca[i], 32'h8 + 32'(i));
      chk($sformatf("incr_first%0d", i), 32'(cf[i]),
          32'(i == 0));
      chk($sformatf("incr_last%0d", i), 32'(cl[i]),
          32'(i == 3));
    end
    chk("incr_we", 32'(cw[1]), 0);
    chk("incr_id", 32'(cid[2]), 1);

    // AW WRAP burst then B
    send_aw(32'h60, 2'd2, 8'd3, 4'd5, 1'b0);
    collect(4);
    chk("wrap_a0", ca[0], 32'h3);
    chk("wrap_a1", ca[1], 32'h0);
    chk("wrap_a2", ca[2], 32'h1);
    chk("wrap_a3", ca[3], 32'h2);
    chk("wrap_we", 32'(cw[0]), 1);
    chk("b_before_done", 32'(axi_b_valid), 0);
    done_pulse();
    chk("b_valid", 32'(axi_b_valid), 1);
    chk("b_resp", 32'(axi_b_payload_resp), 0);
    chk("b_id", 32'(axi_b_payload_id), 0);
    chk("b_first", 32'(axi_b_first), 1);
    chk("b_last", 32'(axi_b_last), 1);
    axi_b_ready = 1'b1;
    tick();
    axi_b_ready = 1'b0;
    chk("b_popped", 32'(axi_b_valid), 0);

    // round-robin between simultaneous AW/AR
`ifdef AXI_QOS_ARB_EN
    exp_we = 1'b1;
`else
    exp_we = 1'b0;
`endif
    axi_b_ready = 1'b1;
    axi_aw_payload_qos = 4'd5;
    axi_ar_payload_qos = 4'd2;
    for (int p = 0; p < 4; p++) begin
      axi_aw_payload_addr  = 32'h2000 + 32'(p * 32);
      axi_ar_payload_addr  = 32'h1000 + 32'(p * 32);
      axi_aw_payload_burst = 2'd1;
      axi_ar_payload_burst = 2'd1;
      axi_aw_payload_len   = 8'd0;
      axi_ar_payload_len   = 8'd0;
      axi_aw_payload_size  = 4'd5;
      axi_ar_payload_size  = 4'd5;
      axi_aw_valid = 1'b1;
      axi_ar_valid = 1'b1;
      chk("pair_ready",
          32'({axi_aw_ready, axi_ar_ready}), 32'h3);
      tick();
      axi_aw_valid = 1'b0;
      axi_ar_valid = 1'b0;
      collect(2);
      chk($sformatf("pair%0d_g0", p), 32'(cw[0]),
          32'(exp_we));
      chk($sformatf("pair%0d_g1", p), 32'(cw[1]),
          32'(!exp_we));
      done_pulse();
      tick();
      chk("pair_b_drained", 32'(axi_b_valid), 0);
    end
    axi_b_ready = 1'b0;

    // ID FIFO full stalls AW
    for (int k = 0; k < 4; k++)
      send_aw(32'h3000 + 32'(k * 32), 2'd1, 8'd0, 4'd5, 1'b0);
    tick();
    tick();
    tick();
    axi_aw_payload_addr = 32'h4000;
    axi_aw_valid = 1'b1;
    chk("fifo_full_stall", 32'(axi_aw_ready), 0);
    axi_b_ready = 1'b1;
    done_pulse();
    chk("full_b_valid", 32'(axi_b_valid), 1);
    chk("full_still_stall", 32'(axi_aw_ready), 0);
    tick();
    chk("full_b_taken", 32'(axi_b_valid), 0);
    chk("aw_resume", 32'(axi_aw_ready), 1);
    tick();
    axi_aw_valid = 1'b0;
    chk("aw5_held", 32'(axi_aw_ready), 0);
    for (int k = 0; k < 4; k++) begin
      done_pulse();
      tick();
    end
    chk("drain_b", 32'(axi_b_valid), 0);
    axi_b_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    // reserved burst -> SLVERR, B stable under backpressure
    send_aw(32'h500, 2'd3, 8'd0, 4'd5, 1'b1);
    collect(1);
    chk("err_we", 32'(cw[0]), 1);
    chk("err_addr", ca[0], 32'h28);
    done_pulse();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("err_bv%0d", k), 32'(axi_b_valid), 1);
      chk($sformatf("err_resp%0d", k),
          32'(axi_b_payload_resp), 32'h2);
      chk($sformatf("err_id%0d", k),
          32'(axi_b_payload_id), 1);
      tick();
    end
    axi_b_ready = 1'b1;
    tick();
    axi_b_ready = 1'b0;
    chk("err_b_popped", 32'(axi_b_valid), 0);

    // mid-burst asynchronous reset
    native_cmd_ready = 1'b0;
    send_ar(32'h200, 2'd1, 8'd3, 4'd5, 1'b1);
    cn = 0;
    for (int i = 0; i < 10 && !native_cmd_valid; i++)
      tick();
    chk("stuck_valid", 32'(native_cmd_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(native_cmd_valid), 0);
    chk("arst_addr", native_cmd_payload_addr, 0);
    chk("arst_id", 32'(native_cmd_id), 0);
    chk("arst_first", 32'(native_cmd_first), 0);
    chk("arst_ar_ready", 32'(axi_ar_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    native_cmd_ready = 1'b1;
    send_ar(32'h400, 2'd1, 8'd1, 4'd5, 1'b0);
    collect(2);
    chk("post_a0", ca[0], 32'h20);
    chk("post_a1", ca[1], 32'h21);
    chk("post_first", 32'(cf[0]), 1);
    chk("post_last", 32'(cl[1]), 1);
    chk("post_we", 32'(cw[0]), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
